// File: rtl/mdu_ctrl_if.sv
// Purpose : handshake/data bundle between the E-stage issue logic and the MDU sequencer.
// Latency : none; this is wiring only.
// Backpressure: stall_req travels back to the F/D stages. The DUT takes the slave modport.
// Signals : start/mdu_op/rs_data/rt_data/d_use_mdu flow into the MDU.
//           busy/stall_req/hi/lo/mf_data flow out of the MDU.
interface mdu_ctrl_if;
    logic        start;      // E-stage instruction is an MDU op; valid for one cycle
    logic [3:0]  mdu_op;     // 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
    logic [31:0] rs_data;    // operand A / mthi, mtlo source
    logic [31:0] rt_data;    // operand B (divisor)
    logic        d_use_mdu;  // D-stage instruction is any MDU op
    logic        busy;       // operation in flight
    logic        stall_req;  // stall F/D, bubble into E
    logic [31:0] hi;         // HI register
    logic [31:0] lo;         // LO register
    logic [31:0] mf_data;    // mfhi/mflo read data

    modport master (
        output start, mdu_op, rs_data, rt_data, d_use_mdu,
        input  busy, stall_req, hi, lo, mf_data
    );

    modport slave (
        input  start, mdu_op, rs_data, rt_data, d_use_mdu,
        output busy, stall_req, hi, lo, mf_data
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Purpose : multiply/divide sequencer owning HI/LO; it models a fixed multi-cycle latency for mult/div.
// Latency : mult/multu take MULT_CYCLES busy cycles and div/divu take DIV_CYCLES. mthi/mtlo write in one edge.
// Backpressure: while busy, start is ignored. stall_req holds the next MDU instruction in D.
// Ports   : clk, reset (sync, active-high), bus (mdu_ctrl_if.slave). Parameters: MULT_CYCLES, DIV_CYCLES.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [3:0]     r_op;

    // Start-side decode
    logic           w_is_arith;
    assign w_is_arith = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);

    // Products on the latched operands. Both operands are extended to 64 bits so the
    // low 64 bits of the product are the exact 32x32 result.
    logic [63:0]    w_prod_s;
    logic [63:0]    w_prod_u;
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Division. The divisor is forced to 1 when it is zero. That result is discarded,
    // and forcing the divisor avoids a divide-by-zero in the datapath.
    // Signed division is done on magnitudes, then the signs are fixed up. This keeps
    // 0x80000000 / -1 well defined: the result wraps to 0x80000000 with remainder 0.
    logic           w_div_zero;
    logic [31:0]    w_b_safe;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [31:0]    w_a_mag;
    logic [31:0]    w_b_mag;
    logic [31:0]    w_uq;
    logic [31:0]    w_ur;
    logic [31:0]    w_mq;
    logic [31:0]    w_mr;
    logic [31:0]    w_sq;
    logic [31:0]    w_sr;

    assign w_div_zero = (r_b == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : r_b;
    assign w_a_neg    = r_a[31];
    assign w_b_neg    = w_b_safe[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag    = w_b_neg ? (32'd0 - w_b_safe) : w_b_safe;
    assign w_uq       = r_a / w_b_safe;
    assign w_ur       = r_a % w_b_safe;
    assign w_mq       = w_a_mag / w_b_mag;
    assign w_mr       = w_a_mag % w_b_mag;
    assign w_sq       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_mq) : w_mq;
    assign w_sr       = w_a_neg ? (32'd0 - w_mr) : w_mr;   // remainder takes the dividend's sign

    // Result written to HI/LO at the last busy edge
    logic [31:0]    w_res_hi;
    logic [31:0]    w_res_lo;
    logic           w_res_wr;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_wr = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_wr = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_wr = !w_div_zero;
            end
            OP_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_res_wr = !w_div_zero;
            end
            default: begin
                w_res_wr = 1'b0;
            end
        endcase
    end

    // Sequencer: IDLE accepts ops and RUN counts down the fixed latency.
    // Because start is only looked at in IDLE, it is ignored for free while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_is_arith) begin
                            r_a     <= bus.rs_data;
                            r_b     <= bus.rt_data;
                            r_op    <= bus.mdu_op;
                            r_cnt   <= (bus.mdu_op >= OP_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else if (bus.mdu_op == OP_MTHI) begin
                            r_hi <= bus.rs_data;
                        end else if (bus.mdu_op == OP_MTLO) begin
                            r_lo <= bus.rs_data;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt > CW'(1)) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        if (w_res_wr) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The launch cycle also stalls: the op is not busy yet, but it will be next cycle.
    assign bus.stall_req = bus.d_use_mdu & (r_busy | (bus.start & w_is_arith));

    always_comb begin
        bus.mf_data = 32'd0;
        if (bus.mdu_op == OP_MFHI) begin
            bus.mf_data = r_hi;
        end else if (bus.mdu_op == OP_MFLO) begin
            bus.mf_data = r_lo;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Purpose : self-checking bench for mdu_ctrl with directed corner cases and randomized ops.
// Latency : one op at a time; each op is followed until busy falls, bounded to 64 cycles.
// Backpressure: stall_req is checked in the launch cycle, in every busy cycle, and after release.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural meaning of each op, using 64-bit integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output int n);
        longint    sa, sb, q, r;
        logic [63:0] p;
        n = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin
                p = 64'(sa * sb);
                h = p[63:32]; l = p[31:0]; n = MC;
            end
            4'd2: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32]; l = p[31:0]; n = MC;
            end
            4'd3: begin
                n = DC;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa - q * sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
            4'd4: begin
                n = DC;
                if (b != 0) begin
                    l = a / b; h = a % b;
                end
            end
            4'd5: h = a;
            4'd6: l = a;
            default: n = 0;
        endcase
    endfunction

    // Called and returns at negedge+1. The op is driven in the current cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic du, input string tag);
        int n, nexp;
        logic [31:0] mfexp;
        logic sexp;
        mfexp = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        sexp  = du && (op >= 4'd1) && (op <= 4'd4);
        model(op, a, b, m_hi, m_lo, nexp);
        bus.start = 1'b1; bus.mdu_op = op; bus.rs_data = a; bus.rt_data = b; bus.d_use_mdu = du;
        #1;
        chk({tag, "_stall_launch"}, 32'(bus.stall_req), 32'(sexp));
        chk({tag, "_mf_data"}, bus.mf_data, mfexp);
        @(negedge clk);
        bus.start = 1'b0; bus.mdu_op = 4'd0;
        #1;
        n = 0;
        while (bus.busy === 1'b1 && n < 64) begin
            chk({tag, "_stall_busy"}, 32'(bus.stall_req), 32'(du));
            n++;
            @(negedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(nexp));
        chk({tag, "_stall_after"}, 32'(bus.stall_req), 32'd0);
        chk({tag, "_hi"}, bus.hi, m_hi);
        chk({tag, "_lo"}, bus.lo, m_lo);
    endtask

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a, b;
        checks = 0; failures = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1;
        bus.start = 1'b0; bus.mdu_op = 4'd0; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
        bus.d_use_mdu = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        reset = 1'b0; bus.d_use_mdu = 1'b0;
        @(negedge clk); #1;

        // Reset in the middle of a mult must cancel it with no late write.
        bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
        @(negedge clk); bus.start = 1'b0; bus.mdu_op = 4'd0; #1;
        chk("midrst_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("midrst_late_hi", bus.hi, 32'd0);
        chk("midrst_late_lo", bus.lo, 32'd0);
        chk("midrst_late_busy", 32'(bus.busy), 32'd0);

        // Directed arithmetic cases
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, "mult");
        chk("mult_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFFFFFA);
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, "multu");
        chk("multu_hi_const", bus.hi, 32'h00000002);
        chk("multu_lo_const", bus.lo, 32'hFFFFFFFA);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, "div");
        chk("div_lo_const", bus.lo, 32'hFFFFFFFD);
        chk("div_hi_const", bus.hi, 32'hFFFFFFFF);
        run_op(4'd4, 32'd7, 32'd0, 1'b0, "divu_zero");
        chk("divu_zero_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("divu_zero_lo_const", bus.lo, 32'hFFFFFFFD);

        // A start while busy is ignored: mthi during a mult must not land.
        bus.start = 1'b1; bus.mdu_op = 4'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd4; bus.d_use_mdu = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.mdu_op = 4'd0; #1;
        @(negedge clk); #1;
        bus.start = 1'b1; bus.mdu_op = 4'd5; bus.rs_data = 32'h1234; #1;
        chk("ign_stall", 32'(bus.stall_req), 32'd1);
        @(negedge clk); bus.start = 1'b0; bus.mdu_op = 4'd0; #1;
        n = 0;
        while (bus.busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk); #1;
        end
        chk("ign_busy_fell", 32'(bus.busy), 32'd0);
        chk("ign_hi", bus.hi, 32'd0);
        chk("ign_lo", bus.lo, 32'd12);
        m_hi = 32'd0; m_lo = 32'd12;

        run_op(4'd5, 32'h1234, 32'd0, 1'b1, "mthi");
        chk("mthi_hi_const", bus.hi, 32'h00001234);
        bus.mdu_op = 4'd7; #1;
        chk("mfhi_const", bus.mf_data, 32'h00001234);
        bus.mdu_op = 4'd0;
        run_op(4'd8, 32'd0, 32'd0, 1'b1, "mflo");

        // Overflow divide, then a multu back-to-back in the cycle busy falls.
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
        chk("div_ovf_lo_const", bus.lo, 32'h80000000);
        chk("div_ovf_hi_const", bus.hi, 32'h00000000);
        run_op(4'd2, 32'h00010000, 32'h00010001, 1'b1, "b2b_multu");
        chk("b2b_multu_hi_const", bus.hi, 32'h00000001);
        chk("b2b_multu_lo_const", bus.lo, 32'h00010000);

        // Randomized ops, including op 0, unknown ops and zero divisors
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            run_op(op, a, b, 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
